// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO stream serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int MAX_WIDTH = 64;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter with enable, synchronous clear and a registered terminal-count flag.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int CNT_W = cnt_width(NBITS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_q;
  logic             last_d;

  // The flag is computed from the next count so it lines up with the bit it marks.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    last_d = (cnt_d == CNT_W'(NBITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign last = last_q;

endmodule

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_stream_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  // Handshake: a word moves on in_valid & in_ready, a bit moves on
  // out_valid & out_ready, both sampled at the rising edge of clk.
  piso_state_t      state_q;
  piso_state_t      state_d;
  logic [NBITS-1:0] sr_q;
  logic [NBITS-1:0] sr_d;
  logic             mode_q;
  logic             mode_d;
  logic             out_bit_q;
  logic             out_bit_d;
  logic             accept;
  logic             xfer;
  logic             last_xfer;
  logic             cnt_clr;
  logic             cnt_en;
  logic             last_flag;
  logic [NBITS-1:0] load_msb;
  logic [NBITS-1:0] load_lsb;

`ifdef PISO_PARITY_EN
  logic parity;
  assign parity   = even_parity(MAX_WIDTH'(in_data));
  assign load_msb = {in_data, parity};
  assign load_lsb = {parity, in_data};
`else
  assign load_msb = in_data;
  assign load_lsb = in_data;
`endif

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & out_last;
  assign cnt_clr   = accept | last_xfer;
  assign cnt_en    = xfer & ~out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_xfer && !accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is the only combinational output; it is held low during reset.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = rst_n;
      SHIFT:   in_ready = rst_n & out_ready & out_last;
      default: in_ready = 1'b0;
    endcase
  end

  assign out_valid = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT);

  always_comb begin
    sr_d   = sr_q;
    mode_d = mode_q;
    if (accept) begin
      mode_d = lsb_first;
      sr_d   = lsb_first ? load_lsb : load_msb;
    end else if (xfer) begin
      sr_d = mode_q ? {1'b0, sr_q[NBITS-1:1]} : {sr_q[NBITS-2:0], 1'b0};
    end
    // Registering the head of the next shift value keeps out_bit a flop.
    out_bit_d = 1'b0;
    if (state_d == SHIFT) begin
      out_bit_d = mode_d ? sr_d[0] : sr_d[NBITS-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q      <= '0;
      mode_q    <= 1'b0;
      out_bit_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      mode_q    <= mode_d;
      out_bit_q <= out_bit_d;
    end
  end

  piso_bit_counter #(
    .NBITS(NBITS),
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .last (last_flag)
  );

  assign out_bit  = out_bit_q;
  assign out_last = last_flag;

endmodule
